// File: rtl/wts_bus_pkg.sv
// Shared FSM state type, parameter range limits and a clamp helper for the
// WTS slot bus bridge.
package wts_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        READ_HOLD = 2'd3
    } bus_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_LEN_MIN  = 1;
    localparam int FILTER_LEN_MAX  = 4;

    // Wide enough for both the filter run counter and the sync flush counter.
    localparam int CNT_W = 3;

    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/wts_sync_filter.sv
// Synchroniser plus run-length glitch filter for one active-low slot strobe.
// Outputs the filtered level and a one-cycle pulse when it falls.
module wts_sync_filter
    import wts_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1
) (
    input  logic clk,
    input  logic nreset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int SYNC_N = clamp_int(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    localparam int FILT_N = clamp_int(FILTER_LEN, FILTER_LEN_MIN, FILTER_LEN_MAX);

    logic [SYNC_N-1:0] sync_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  flush_q;
    logic              armed_q;
    logic              level_q;
    logic              fall_q;
    logic              sync_out;
    logic              differ;
    logic              change;

    assign sync_out = sync_q[SYNC_N-1];
    assign differ   = (sync_out != level_q);
    assign change   = differ && (cnt_q == CNT_W'(FILT_N - 1));

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            flush_q <= '0;
            armed_q <= 1'b0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], raw};

            // Falls are only reported once the strobe has been seen high after
            // reset, so a strobe held low across reset release is ignored.
            if (flush_q != CNT_W'(SYNC_N)) begin
                flush_q <= flush_q + CNT_W'(1);
            end else if (sync_out) begin
                armed_q <= 1'b1;
            end

            if (change) begin
                level_q <= sync_out;
                cnt_q   <= '0;
            end else if (differ) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end

            fall_q <= change & level_q & armed_q;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/wts_bus_bridge.sv
// MSX cartridge slot front-end for wts_core: strobe conditioning, request FSM,
// read hold register and registered audio mixer (mixer enabled by WTS_MONO_MIX_EN).
module wts_bus_bridge
    import wts_bus_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int SAMPLE_W    = 12,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                slot_nsltsl,
    input  logic                slot_nrd,
    input  logic                slot_nwr,
    input  logic [ADDR_W-1:0]   slot_a,
    input  logic [DATA_W-1:0]   slot_d_in,
    output logic [DATA_W-1:0]   slot_d_out,
    output logic                slot_d_oe,
    output logic                wrreq,
    output logic                rdreq,
    output logic                wr_active,
    output logic                rd_active,
    output logic [ADDR_W-1:0]   bus_a,
    output logic [DATA_W-1:0]   bus_d,
    input  logic [DATA_W-1:0]   core_q,
    input  logic                sw_mono,
    input  logic [SAMPLE_W-1:0] core_left,
    input  logic [SAMPLE_W-1:0] core_right,
    output logic [SAMPLE_W-1:0] left_out,
    output logic [SAMPLE_W-1:0] right_out,
    output logic [1:0]          dbg_state
);

    bus_state_e state_q, state_d;
    logic       sltsl_lvl, sltsl_fall;
    logic       nrd_lvl, nrd_fall;
    logic       nwr_lvl, nwr_fall;
    logic       load_rd;
    logic       unused_sltsl_fall;

    wts_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sltsl (
        .clk(clk), .nreset(nreset), .raw(slot_nsltsl), .level(sltsl_lvl), .fall(sltsl_fall)
    );
    wts_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_nrd (
        .clk(clk), .nreset(nreset), .raw(slot_nrd), .level(nrd_lvl), .fall(nrd_fall)
    );
    wts_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_nwr (
        .clk(clk), .nreset(nreset), .raw(slot_nwr), .level(nwr_lvl), .fall(nwr_fall)
    );

    assign unused_sltsl_fall = sltsl_fall;

    // Request protocol: wrreq/rdreq are single-cycle pulses with no back-pressure;
    // bus_a/bus_d are stable during the pulse and stay frozen until IDLE returns,
    // and core_q must be valid the cycle after rdreq.
    always_comb begin
        state_d = state_q;
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        load_rd = 1'b0;
        case (state_q)
            IDLE: begin
                if (nwr_fall && !sltsl_lvl) begin
                    wrreq   = 1'b1;
                    state_d = WRITE;
                end else if (nrd_fall && !sltsl_lvl) begin
                    rdreq   = 1'b1;
                    state_d = READ_WAIT;
                end
            end
            WRITE: begin
                if (nwr_lvl) state_d = IDLE;
            end
            READ_WAIT: begin
                load_rd = 1'b1;
                state_d = READ_HOLD;
            end
            READ_HOLD: begin
                if (nrd_lvl) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= IDLE;
            bus_a      <= '0;
            bus_d      <= '0;
            slot_d_out <= '0;
        end else begin
            state_q <= state_d;
            // Track the pins while idle so the request pulse already sees its address/data.
            if (state_q == IDLE && !wrreq && !rdreq) begin
                bus_a <= slot_a;
                bus_d <= slot_d_in;
            end
            if (load_rd) slot_d_out <= core_q;
        end
    end

    assign wr_active = (state_q == WRITE);
    assign rd_active = (state_q == READ_WAIT) || (state_q == READ_HOLD);
    assign slot_d_oe = (state_q == READ_HOLD) & ~slot_nrd & ~slot_nsltsl;
    assign dbg_state = state_q;

`ifdef WTS_MONO_MIX_EN
    logic [SAMPLE_W:0]   mix_sum;
    logic [SAMPLE_W-1:0] mono;

    assign mix_sum = {1'b0, core_left} + {1'b0, core_right};
    assign mono    = mix_sum[SAMPLE_W:1];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            left_out  <= '0;
            right_out <= '0;
        end else begin
            left_out  <= sw_mono ? mono : core_left;
            right_out <= sw_mono ? mono : core_right;
        end
    end
`else
    logic unused_sw_mono;
    assign unused_sw_mono = sw_mono;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            left_out  <= '0;
            right_out <= '0;
        end else begin
            left_out  <= core_left;
            right_out <= core_right;
        end
    end
`endif

endmodule
